alu_divider: RTL and testbench

//  Iterative restoring divider for the MIPS ALU, used for DIV/DIVU. It sits downstream of
//  the ALU subtractor: each cycle it forms (partial remainder - divisor) and takes the

---
 rtl/alu_div_pkg.sv | 9 +
 rtl/alu_divider_div_step.sv | 18 +
 rtl/alu_divider.sv | 100 ++++++++++
 tb/tb_alu_divider.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_div_pkg.sv
// alu_div_pkg: shared state type, default sizes and magnitude helper for the iterative divider
package alu_div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;
    function automatic logic [DIV_WIDTH-1:0] abs_u(input logic [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? -v : v;
    endfunction
endpackage

// File: rtl/alu_divider_div_step.sv
// div_step: one restoring iteration, shift in the next dividend bit and trial-subtract the divisor
module div_step
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);
    logic [WIDTH:0] sh, diff;
    assign sh      = {rem_i, dvd_msb_i};
    assign diff    = sh - {1'b0, divisor_i};
    assign q_bit_o = ~diff[WIDTH];
    assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
endmodule

// File: rtl/alu_divider.sv
// alu_divider: iterative restoring DIV/DIVU unit for LO/HI; ALU_DIV_ZERO_DETECT_EN enables the divide-by-zero shortcut
module alu_divider
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DivZero
);
    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, dvd_q, dvs_q, q_q, r_q, rem_n, q_fix, r_fix;
    logic             sgn_q, a_neg_q, b_neg_q, dz_q, q_bit, accept, zero_op;

    assign accept = start && (state_q == IDLE || state_q == DONE);
`ifdef ALU_DIV_ZERO_DETECT_EN
    assign zero_op = B == '0;
`else
    assign zero_op = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (rem_n),
        .q_bit_o   (q_bit)
    );

    assign q_fix   = (sgn_q && (a_neg_q ^ b_neg_q)) ? -dvd_q : dvd_q;
    assign r_fix   = (sgn_q && a_neg_q) ? -rem_q : rem_q;
    assign busy    = state_q == RUN || state_q == FIX;
    assign done    = state_q == DONE;
    assign Q       = q_q;
    assign R       = r_q;
    assign DivZero = dz_q;

    // next-state logic: accept from IDLE/DONE, WIDTH RUN cycles, one FIX cycle, one DONE pulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = accept ? (zero_op ? DONE : RUN) : IDLE;
            RUN:        state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIX : RUN;
            FIX:        state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // operand latch, shift/subtract iterations, and sign fix written to the visible Q/R
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            sgn_q   <= 1'b0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= Signed ? abs_u(A) : A;
            dvs_q   <= Signed ? abs_u(B) : B;
            sgn_q   <= Signed;
            a_neg_q <= A[WIDTH-1];
            b_neg_q <= B[WIDTH-1];
            dz_q    <= zero_op;
            if (zero_op) begin
                q_q <= '1;
                r_q <= A;
            end
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= rem_n;
            dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
        end else if (state_q == FIX) begin
            q_q <= q_fix;
            r_q <= r_fix;
        end
    end
endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: directed and random scoreboard checks of quotient, remainder, latency and handshake
module tb_alu_divider;
    logic        clk = 1'b0;
    logic        reset, start, Signed;
    logic [31:0] A, B, Q, R;
    logic        busy, done, DivZero;
    int          n_cmp = 0;
    int          n_mis = 0;

`ifdef ALU_DIV_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        string       tag;
    } want_t;
    want_t sb[$];

    alu_divider dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .Signed  (Signed),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Q       (Q),
        .R       (R),
        .DivZero (DivZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic push_op(input string tag, input logic [31:0] q, input logic [31:0] r,
                           input logic dz, input int lat);
        sb.push_back('{q, r, dz, lat, tag});
    endtask

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        Signed = s;
        A      = a;
        B      = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int k0, input bit pulse);
        int    k  = k0;
        int    nb = k0;
        want_t w;
        while (!done && k < 100) begin
            if (busy) nb++;
            step();
            k++;
        end
        w = sb.pop_front();
        chk({w.tag, " latency"}, k, w.lat);
        chk({w.tag, " busy cycles"}, nb, w.lat);
        chk({w.tag, " Q"}, Q, w.q);
        chk({w.tag, " R"}, R, w.r);
        chk({w.tag, " DivZero"}, {31'b0, DivZero}, {31'b0, w.dz});
        if (pulse) begin
            step();
            chk({w.tag, " done pulse"}, {31'b0, done}, 32'd0);
            chk({w.tag, " Q hold"}, Q, w.q);
        end
    endtask

    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    initial begin
        logic [31:0] ra, rb, mq, mr;
        logic        rs;
        reset  = 1'b1;
        start  = 1'b0;
        Signed = 1'b0;
        A      = '0;
        B      = '0;
        repeat (2) step();
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset Q", Q, 32'd0);
        chk("reset R", R, 32'd0);
        chk("reset DivZero", {31'b0, DivZero}, 32'd0);
        reset = 1'b0;
        step();

        push_op("divu 100/7", 32'd14, 32'd2, 1'b0, 33);
        issue(1'b0, 32'd100, 32'd7);
        collect(0, 1'b1);

        push_op("div -7/2", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
        issue(1'b1, 32'hFFFFFFF9, 32'd2);
        collect(0, 1'b1);

        push_op("div 7/-2", 32'hFFFFFFFD, 32'd1, 1'b0, 33);
        issue(1'b1, 32'd7, 32'hFFFFFFFE);
        collect(0, 1'b1);

        push_op("div min/-1", 32'h80000000, 32'd0, 1'b0, 33);
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
        collect(0, 1'b1);

        push_op("divu max/1", 32'hFFFFFFFF, 32'd0, 1'b0, 33);
        issue(1'b0, 32'hFFFFFFFF, 32'd1);
        collect(0, 1'b1);

        push_op("divu 5/0", 32'hFFFFFFFF, 32'd5, ZD, ZD ? 0 : 33);
        issue(1'b0, 32'd5, 32'd0);
        collect(0, 1'b1);

        push_op("ignored start", 32'd8, 32'd2, 1'b0, 33);
        issue(1'b0, 32'd50, 32'd6);
        repeat (9) step();
        chk("busy before stray start", {31'b0, busy}, 32'd1);
        A     = 32'd999;
        B     = 32'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        collect(10, 1'b1);

        push_op("b2b first", 32'd9, 32'd0, 1'b0, 33);
        issue(1'b0, 32'd81, 32'd9);
        collect(0, 1'b0);
        push_op("b2b second", 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33);
        issue(1'b1, 32'hFFFFFF9C, 32'd7);
        chk("b2b accepted busy", {31'b0, busy}, 32'd1);
        collect(0, 1'b1);

        issue(1'b0, 32'd12345, 32'd3);
        repeat (14) step();
        reset = 1'b1;
        step();
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort done", {31'b0, done}, 32'd0);
        chk("abort Q", Q, 32'd0);
        chk("abort R", R, 32'd0);
        reset = 1'b0;
        step();
        push_op("divu 1000/10", 32'd100, 32'd0, 1'b0, 33);
        issue(1'b0, 32'd1000, 32'd10);
        collect(0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            rs = 1'(i % 2);
            ra = $urandom();
            rb = $urandom() >> $urandom_range(0, 28);
            if (rb == 32'd0 || rb == 32'hFFFFFFFF) rb = 32'd3;
            if (rs && $urandom_range(0, 1) == 1) rb = -rb;
            model(rs, ra, rb, mq, mr);
            push_op($sformatf("rand%0d %s %h/%h", i, rs ? "div" : "divu", ra, rb), mq, mr, 1'b0, 33);
            issue(rs, ra, rb);
            collect(0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
